xc_pmul_seq: RTL
================

# xc_pmul_seq

Iterative shift-add sequencer for the XCrypto packed multiply instructions (`xc.pmul.l` and `xc.pmul.h`). It accepts two 32-bit operands, a pack width and a high/low select from the execute stage. It computes every lane product in parallel, one multiplier bit per cycle, and returns the selected half of each lane product packed into a 32-bit result. One instance sits in the execute stage as a shared multi-cycle unit behind a valid/ready handshake.

## Interface
- No parameters. XLEN is fixed at 32.
- `g_clk` input 1: the single clock. All state changes on its rising edge.
- `g_reset` input 1: asynchronous, active-high reset.
- `flush` input 1: aborts any operation in progress; the result is discarded.
- `valid` input 1: request. The requester holds it high until `ready`.
- `rs1` input 32: multiplicand, packed lanes.
- `rs2` input 32: multiplier, packed lanes.
- `pw` input 2: pack width.
  - `00`: 1×32-bit lane.
  - `01`: 2×16-bit lanes.
  - `10`: 4×8-bit lanes.
  - `11`: 8×4-bit lanes.
- `hi` input 1: 0 returns the low lw bits of each lane product (`pmul.l`); 1 returns the high lw bits (`pmul.h`).
- `ready` output 1: one-cycle pulse. `result` is valid during this cycle.
- `busy` output 1: high while in RUN or DONE.
- `result` output 32: packed lane results.

## Operation
- States and transitions:
  - IDLE: go to RUN if `valid & ~flush`.
  - RUN: go to DONE when `count == lw-1` at the clock edge.
  - DONE: always go to IDLE.
  - Any state: go to IDLE on `flush`.
- Accept (IDLE with `valid` high):
  - Latch `rs1` into A.
  - Latch `rs2` into L.
  - Clear H.
  - Latch `pw` and `hi`.
  - Set `count = 0`.
  - After accept, the inputs are don't-care until `ready`.
- lw is the lane width: 32, 16, 8 or 4.
- RUN step. For each lane j, all lanes in parallel:
  - If `L_j[0]`, compute `{c_j,H_j} = H_j + A_j` (lw+1 bits). Otherwise set `c_j = 0`.
  - Shift `{c_j,H_j,L_j}` right by 1 and keep the low 2·lw bits.
  - No bit crosses a lane boundary in the add or the shift. Carries are masked and shifted in at each lane's MSB.
  - Increment `count`.
- Completion: after lw steps, `{H_j,L_j} = A_j × B_j` exactly, as unsigned. Signedness is not supported.
- DONE:
  - `result` = L when `hi` = 0.
  - `result` = H when `hi` = 0 is false, i.e. `hi` = 1.
  - `result` is registered.
  - `ready` = 1 for exactly this cycle.
- `result` holds its value until the next accept. It is meaningful only while `ready` = 1.
- `flush`:
  - Has priority over `valid` and over completion.
  - A `flush` in the DONE cycle suppresses nothing already visible, because `ready` is combinational from state. The requester ignores `ready` when it flushes.
  - The next state is IDLE and no new request is accepted that cycle.
- Back-to-back requests: `valid` still high in the IDLE cycle after DONE starts a new operation. The requester must drop `valid` in the cycle after `ready` unless it intends a new request.
- Reset mid-operation: the state goes to IDLE immediately (asynchronous) and partial products are lost.

## Timing
- Reset values:
  - `ready` = 0.
  - `busy` = 0.
  - `result` = 0.
  - state = IDLE.
  - `count` = 0.
  - A, H and L = 0.
- `valid` is sampled in cycle t while IDLE.
- RUN occupies cycles t+1 … t+lw.
- DONE occupies cycle t+lw+1, with `ready` = 1.
- Latency from the accept cycle to `ready`:

| `pw` | lw | Latency (cycles) |
|---|---|---|
| `00` | 32 | 33 |
| `01` | 16 | 17 |
| `10` | 8 | 9 |
| `11` | 4 | 5 |

- Throughput: one operation per lw+2 cycles when `valid` is held continuously.
- `busy` is high in cycles t+1 … t+lw+1.
- `ready` never asserts in two consecutive cycles.
- `ready` is low while `busy` = 0.

## Test plan
- `pw=00`, `hi=1`, `rs1=0x00010000`, `rs2=0x00010000` → `ready` at t+33 with `result=0x00000001`. The same operands with `hi=0` give `result=0x00000000`.
- `pw=01`, `rs1=0xFFFF0003`, `rs2=0x00020005`:
  - `hi=0` → `result=0xFFFE000F` at t+17.
  - `hi=1` → `result=0x00010000`.
  - This checks that no carry crosses from lane 0 into lane 1.
- `pw=10`, `hi=0`, `rs1=0x10203040`, `rs2=0x02020202` → `result=0x20406080` at t+9. With `hi=1` → `result=0x00000000`.
- `pw=11`, `rs1=rs2=0xFFFFFFFF`:
  - `hi=0` → `result=0x11111111` at t+5.
  - `hi=1` → `result=0xEEEEEEEE`.
- Abort and back-to-back:
  - Start a `pw=00` operation and assert `flush` at t+10 → IDLE at t+11, no `ready` pulse, `busy=0`.
  - Then hold `valid` through two consecutive `pw=11` requests → `ready` pulses exactly 6 cycles apart.
- Assert `g_reset` asynchronously mid-RUN → `busy`, `ready` and `result` go to 0 without waiting for a clock edge. After release, no `ready` appears until a new accept.

Source files
------------

// File: rtl/xc_pmul_seq_if.sv
// Request/response bundle between the execute stage and the packed-multiply sequencer.
interface xc_pmul_seq_if;
  logic        valid;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  pw;
  logic        hi;
  logic        ready;
  logic        busy;
  logic [31:0] result;

  modport master (output valid, flush, rs1, rs2, pw, hi, input ready, busy, result);
  modport slave  (input valid, flush, rs1, rs2, pw, hi, output ready, busy, result);
endinterface

// File: rtl/xc_pmul_seq.sv
// Shift-add packed multiplier: one multiplier bit per cycle, all lanes in parallel.
// The datapath is built from 4-bit slices whose carry chain is cut at lane boundaries.

module xc_pmul_nib (
  input  logic [3:0] h,
  input  logic [3:0] a,
  input  logic       en,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, h} + {1'b0, a & {4{en}}} + {4'b0, cin};
endmodule

module xc_pmul_seq (
  input  logic          g_clk,
  input  logic          g_reset,
  xc_pmul_seq_if.slave  bus
);
  localparam int NIB = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] a_q, h_q, l_q, res_q;
  logic [31:0] h_sum, h_nxt, l_nxt;
  logic [1:0]  pw_q;
  logic        hi_q;
  logic [4:0]  count;
  logic [4:0]  lw_m1;
  logic [2:0]  lwn_m1;
  logic [NIB-1:0] nib_cout;

  always_comb begin
    case (pw_q)
      2'b00:   lw_m1 = 5'd31;
      2'b01:   lw_m1 = 5'd15;
      2'b10:   lw_m1 = 5'd7;
      default: lw_m1 = 5'd3;
    endcase
  end
  assign lwn_m1 = lw_m1[4:2];

  // Each slice adds A into H only if its lane's current multiplier bit is set;
  // the carry-in is forced to zero on the first slice of every lane.
  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic       en, cin, cout;
    logic [3:0] sum;
    if (i == 0) begin : g_c0
      assign cin = 1'b0;
    end else begin : g_cn
      assign cin = ((3'(i) & lwn_m1) != 3'd0) & g_nib[i-1].cout;
    end
    assign en = l_q[{3'(i) & ~lwn_m1, 2'b00}];
    xc_pmul_nib u_nib (
      .h(h_q[4*i +: 4]), .a(a_q[4*i +: 4]), .en(en), .cin(cin),
      .sum(sum), .cout(cout)
    );
    assign h_sum[4*i +: 4] = sum;
    assign nib_cout[i]     = cout;
  end

  // Per-lane right shift of {c,H,L}: the lane carry enters H's MSB and
  // H's LSB enters L's MSB.
  always_comb begin
    h_nxt = '0;
    l_nxt = '0;
    for (int k = 0; k < 32; k++) begin
      if ((5'(k) & lw_m1) == lw_m1) begin
        h_nxt[k] = nib_cout[3'(k >> 2)];
        l_nxt[k] = h_sum[5'(k) - lw_m1];
      end else begin
        h_nxt[k] = h_sum[5'(k + 1)];
        l_nxt[k] = l_q[5'(k + 1)];
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid) state_nxt = RUN;
      RUN:     if (count == lw_m1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      a_q   <= '0;
      h_q   <= '0;
      l_q   <= '0;
      res_q <= '0;
      pw_q  <= '0;
      hi_q  <= 1'b0;
      count <= '0;
    end else if (state == IDLE && state_nxt == RUN) begin
      a_q   <= bus.rs1;
      l_q   <= bus.rs2;
      h_q   <= '0;
      pw_q  <= bus.pw;
      hi_q  <= bus.hi;
      count <= '0;
    end else if (state == RUN && !bus.flush) begin
      h_q   <= h_nxt;
      l_q   <= l_nxt;
      count <= count + 5'd1;
      if (state_nxt == DONE) res_q <= hi_q ? h_nxt : l_nxt;
    end
  end

  assign bus.ready  = (state == DONE);
  assign bus.busy   = (state != IDLE);
  assign bus.result = res_q;
endmodule
